gelato_inst_decode: RTL and testbench

- Decode stage of the Gelato dispatch path. Accepts raw 32-bit instruction words from fetch over a valid/ready handshake.
- Decodes each word into an inst_t and pushes it as master on gelato_idecode_ibuffer_if toward the instruction buffer.
- Single output register stage with backpressure from the buffer's full indication, plus flush support.

---
 rtl/gelato_inst_decode_pkg.sv | 73 +++++++
 rtl/gelato_idecode_ibuffer_if.sv | 12 +
 rtl/gelato_inst_decode_imm_gen.sv | 28 ++
 rtl/gelato_inst_decode.sv | 122 ++++++++++++
 tb/tb_gelato_inst_decode.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gelato_inst_decode_pkg.sv
// Shared decode types for the Gelato dispatch path.
// Optional GELATO_DECODE_ILLEGAL_TRAP_EN adds the ERROR decode state.
package gelato_types;

  localparam int GELATO_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    INST_R,
    INST_I,
    INST_S,
    INST_B,
    INST_U,
    INST_J,
    INST_ILLEGAL
  } inst_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VALID,
    ST_STALL
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
    ,
    ST_ERROR
`endif
  } decode_state_e;

  typedef struct packed {
    logic [GELATO_XLEN-1:0] pc;
    logic [6:0]             opcode;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [GELATO_XLEN-1:0] imm;
    inst_type_e             inst_type;
  } inst_t;

  function automatic inst_type_e decode_type(
    input logic [6:0] op
  );
    inst_type_e t;
    t = INST_ILLEGAL;
    unique case (1'b1)
      op == OPC_OP:     t = INST_R;
      op == OPC_OP_IMM,
      op == OPC_LOAD,
      op == OPC_JALR,
      op == OPC_SYSTEM,
      op == OPC_FENCE:  t = INST_I;
      op == OPC_STORE:  t = INST_S;
      op == OPC_BRANCH: t = INST_B;
      op == OPC_LUI,
      op == OPC_AUIPC:  t = INST_U;
      op == OPC_JAL:    t = INST_J;
      default:          t = INST_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gelato_idecode_ibuffer_if.sv
// Decode -> instruction buffer link: valid + decoded inst,
// full as backpressure from the buffer.
interface gelato_idecode_ibuffer_if;
  import gelato_types::*;

  logic  valid;
  inst_t inst;
  logic  full;

  modport master (output valid, output inst, input full);
  modport slave  (input valid, input inst, output full);
endinterface

// File: rtl/gelato_inst_decode_imm_gen.sv
// Combinational immediate generator.
// Ports: inst_i raw word, type_i format, imm_o sign-extended immediate.
module gelato_imm_gen
  import gelato_types::*;
(
  input  logic [31:0] inst_i,
  input  inst_type_e  type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    unique case (type_i)
      INST_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      INST_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25],
                       inst_i[11:7]};
      INST_B: imm_o = {{19{inst_i[31]}}, inst_i[31],
                       inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
      INST_U: imm_o = {inst_i[31:12], 12'b0};
      INST_J: imm_o = {{11{inst_i[31]}}, inst_i[31],
                       inst_i[19:12], inst_i[20],
                       inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/gelato_inst_decode.sv
// Decode stage: fetch word in (valid/ready), one output register out,
// backpressure via full, flush, push counter. Option: GELATO_DECODE_ILLEGAL_TRAP_EN.
module gelato_inst_decode
  import gelato_types::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_inst,
  input  logic [XLEN-1:0] fetch_pc,
  gelato_idecode_ibuffer_if.master inst_decoded_data,
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
  output logic            illegal_inst,
  output logic [XLEN-1:0] illegal_pc,
`endif
  output logic [15:0]     decode_count
);

  decode_state_e state_q;
  logic          valid_q;
  inst_t         inst_q;
  logic [15:0]   count_q;
  inst_t         dec;
  inst_type_e    dec_type;
  logic [31:0]   dec_imm;
  logic          full;
  logic          accept;
  logic          push;

  assign full = inst_decoded_data.full;

  assign fetch_ready = rst_n && rdy && !flush &&
                       (state_q == ST_IDLE ||
                        (state_q == ST_VALID && !full));

  assign accept = fetch_valid && fetch_ready;
  assign push   = valid_q && !full && rdy && !flush;

  assign dec_type = decode_type(fetch_inst[6:0]);

  gelato_imm_gen u_imm_gen (
    .inst_i (fetch_inst),
    .type_i (dec_type),
    .imm_o  (dec_imm)
  );

  always_comb begin
    dec           = '0;
    dec.pc        = fetch_pc;
    dec.opcode    = fetch_inst[6:0];
    dec.rd        = fetch_inst[11:7];
    dec.funct3    = fetch_inst[14:12];
    dec.rs1       = fetch_inst[19:15];
    dec.rs2       = fetch_inst[24:20];
    dec.funct7    = fetch_inst[31:25];
    dec.imm       = dec_imm;
    dec.inst_type = dec_type;
    if (dec_type == INST_S || dec_type == INST_B)
      dec.rd = '0;
  end

`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
  logic [XLEN-1:0] ill_pc_q;
  assign illegal_inst = (state_q == ST_ERROR);
  assign illegal_pc   = ill_pc_q;
`endif

  // accept is only possible in IDLE or VALID with full low, and a
  // push is only possible in VALID/STALL, so the arms below cover
  // every transition of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_q.pc <= RESET_PC;
      count_q   <= '0;
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
      ill_pc_q  <= '0;
`endif
    end else if (rdy) begin
      if (push)
        count_q <= count_q + 16'd1;
      if (flush) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end else if (accept) begin
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
        if (dec_type == INST_ILLEGAL) begin
          state_q  <= ST_ERROR;
          valid_q  <= 1'b0;
          ill_pc_q <= fetch_pc;
        end else begin
          state_q <= ST_VALID;
          valid_q <= 1'b1;
          inst_q  <= dec;
        end
`else
        state_q <= ST_VALID;
        valid_q <= 1'b1;
        inst_q  <= dec;
`endif
      end else if (push) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end else if (state_q == ST_VALID && full) begin
        state_q <= ST_STALL;
      end
    end
  end

  assign inst_decoded_data.valid = valid_q;
  assign inst_decoded_data.inst  = inst_q;
  assign decode_count            = count_q;

endmodule

// File: tb/tb_gelato_inst_decode.sv
// Bench for gelato_inst_decode: reference model + directed and random stimulus.
// Honors GELATO_DECODE_ILLEGAL_TRAP_EN when defined.
module tb_gelato_inst_decode;
  import gelato_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_inst = '0;
  logic [31:0] fetch_pc = '0;
  logic [15:0] decode_count;
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
  logic        illegal_inst;
  logic [31:0] illegal_pc;
`endif

  gelato_idecode_ibuffer_if ibuf ();

  gelato_inst_decode #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .flush             (flush),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_inst        (fetch_inst),
    .fetch_pc          (fetch_pc),
    .inst_decoded_data (ibuf.master),
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
    .illegal_inst      (illegal_inst),
    .illegal_pc        (illegal_pc),
`endif
    .decode_count      (decode_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic        m_stalled;
  logic        m_err;
  inst_t       m_inst;
  logic [15:0] m_count;
  logic [31:0] m_ipc;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic inst_type_e ref_type(input logic [6:0] op);
    case (op)
      7'h33:                         return INST_R;
      7'h13, 7'h03, 7'h67, 7'h73,
      7'h0F:                         return INST_I;
      7'h23:                         return INST_S;
      7'h63:                         return INST_B;
      7'h37, 7'h17:                  return INST_U;
      7'h6F:                         return INST_J;
      default:                       return INST_ILLEGAL;
    endcase
  endfunction

  function automatic inst_t ref_dec(input logic [31:0] w,
                                    input logic [31:0] pc);
    inst_t r;
    int    sw;
    sw          = int'(w);
    r           = '0;
    r.pc        = pc;
    r.opcode    = w[6:0];
    r.rd        = w[11:7];
    r.rs1       = w[19:15];
    r.rs2       = w[24:20];
    r.funct3    = w[14:12];
    r.funct7    = w[31:25];
    r.inst_type = ref_type(w[6:0]);
    case (r.inst_type)
      INST_I: r.imm = 32'(sw >>> 20);
      INST_S: r.imm = 32'(((sw >>> 25) << 5) | int'(w[11:7]));
      INST_B: r.imm = 32'(((sw >>> 31) << 12) | (int'(w[7]) << 11)
                     | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
      INST_U: r.imm = w & 32'hFFFF_F000;
      INST_J: r.imm = 32'(((sw >>> 31) << 20) | (int'(w[19:12]) << 12)
                     | (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
      default: r.imm = '0;
    endcase
    if (r.inst_type == INST_S || r.inst_type == INST_B) r.rd = '0;
    return r;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_stalled = 1'b0;
    m_err     = 1'b0;
    m_inst    = '0;
    m_count   = '0;
    m_ipc     = '0;
  endtask

  function automatic logic m_ready(input logic fu, input logic fl,
                                   input logic r);
    return rst_n && r && !fl && !m_err &&
           (!m_valid || (!fu && !m_stalled));
  endfunction

  // One cycle: drive at negedge, compare, advance model, wait edge.
  task automatic cyc(input logic fv, input logic [31:0] w,
                     input logic [31:0] pc, input logic fu,
                     input logic fl, input logic r);
    logic ok;
    logic push;
    @(negedge clk);
    fetch_valid = fv;
    fetch_inst  = w;
    fetch_pc    = pc;
    ibuf.full   = fu;
    flush       = fl;
    rdy         = r;
    #1;
    ok = m_ready(fu, fl, r);
    chk("fetch_ready", 128'(fetch_ready), 128'(ok));
    chk("valid", 128'(ibuf.valid), 128'(m_valid));
    if (m_valid) chk("inst", 128'(ibuf.inst), 128'(m_inst));
    chk("decode_count", 128'(decode_count), 128'(m_count));
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
    chk("illegal_inst", 128'(illegal_inst), 128'(m_err));
    if (m_err) chk("illegal_pc", 128'(illegal_pc), 128'(m_ipc));
`endif
    if (r && rst_n) begin
      if (fl) begin
        m_valid = 1'b0; m_stalled = 1'b0; m_err = 1'b0;
      end else begin
        push = m_valid && !fu;
        if (push) m_count++;
        if (fv && ok) begin
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
          if (ref_type(w[6:0]) == INST_ILLEGAL) begin
            m_err = 1'b1; m_ipc = pc; m_valid = 1'b0;
          end else begin
            m_valid = 1'b1; m_inst = ref_dec(w, pc);
          end
`else
          m_valid = 1'b1; m_inst = ref_dec(w, pc);
`endif
          m_stalled = 1'b0;
        end else if (push) begin
          m_valid = 1'b0; m_stalled = 1'b0;
        end else if (m_valid && fu) begin
          m_stalled = 1'b1;
        end
      end
    end
    @(posedge clk);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    logic [6:0]  ops [12];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 9) != 0)
      w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    ibuf.full = 1'b0;
    model_reset();
    // reset state
    @(negedge clk);
    #1;
    chk("rst_valid", 128'(ibuf.valid), 128'(0));
    chk("rst_ready", 128'(fetch_ready), 128'(0));
    chk("rst_count", 128'(decode_count), 128'(0));
    chk("rst_inst", 128'(ibuf.inst), 128'(0));
    rst_n = 1'b1;

    // back-to-back, 4 words
    cyc(1, 32'hFFB10093, 32'h100, 0, 0, 1);
    #1;
    chk("addi_rd", 128'(ibuf.inst.rd), 128'(1));
    chk("addi_rs1", 128'(ibuf.inst.rs1), 128'(2));
    chk("addi_imm", 128'(ibuf.inst.imm), 128'(32'hFFFFFFFB));
    cyc(1, 32'h002081B3, 32'h104, 0, 0, 1);
    cyc(1, 32'h0020A423, 32'h108, 0, 0, 1);
    cyc(1, 32'h010000EF, 32'h10C, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);
    #1;
    chk("b2b_count", 128'(decode_count), 128'(4));

    // backpressure
    cyc(1, 32'h00500113, 32'h200, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 1, 0, 1);
    cyc(1, 32'h00100093, 32'h204, 1, 0, 1);
    cyc(1, 32'h00100093, 32'h204, 1, 0, 1);
    cyc(1, 32'h00100093, 32'h204, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);
    #1;
    chk("bp_count", 128'(decode_count), 128'(5));

    // flush in STALL with fetch_valid high
    cyc(1, 32'h00700193, 32'h300, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 1, 0, 1);
    cyc(1, 32'h00900213, 32'h304, 1, 1, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);

    // immediate formats
    cyc(1, 32'hFE000EE3, 32'h400, 0, 0, 1);
    #1;
    chk("beq_imm", 128'(ibuf.inst.imm), 128'(32'hFFFFFFFC));
    chk("beq_rd", 128'(ibuf.inst.rd), 128'(0));
    cyc(1, 32'h12345037, 32'h404, 0, 0, 1);
    #1;
    chk("lui_imm", 128'(ibuf.inst.imm), 128'(32'h12345000));
    chk("lui_type", 128'(ibuf.inst.inst_type), 128'(INST_U));

    // rdy low mid-stream
    cyc(1, 32'h00A00293, 32'h408, 0, 0, 1);
    cyc(1, 32'h00B00313, 32'h40C, 0, 0, 0);
    cyc(1, 32'h00B00313, 32'h40C, 0, 0, 0);
    cyc(1, 32'h00B00313, 32'h40C, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 0, 1);

    // illegal opcode
    cyc(1, 32'h0000007F, 32'h500, 0, 0, 1);
`ifdef GELATO_DECODE_ILLEGAL_TRAP_EN
    #1;
    chk("trap_flag", 128'(illegal_inst), 128'(1));
    chk("trap_pc", 128'(illegal_pc), 128'(32'h500));
    cyc(1, 32'h00100093, 32'h504, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 1, 1);
`else
    #1;
    chk("ill_type", 128'(ibuf.inst.inst_type), 128'(INST_ILLEGAL));
`endif
    cyc(0, 32'h0, 32'h0, 0, 0, 1);

    // reset mid-STALL
    cyc(1, 32'h00C00393, 32'h600, 0, 0, 1);
    cyc(0, 32'h0, 32'h0, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", 128'(ibuf.valid), 128'(0));
    chk("rst_stall_count", 128'(decode_count), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd_word(), $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
